fetch_mem_unit: RTL and testbench

- Multicycle-MIPS front end that sits around the microprogrammed control unit.
- Upstream role: holds PC, IR and MDR, and supplies Op to the control unit.
- Downstream role: consumes the control unit's PCWr/PCWrCond/IorD/MemRd/MemWr/IRWr/PCSrc outputs.
- Owns the memory request handshake. Raises Stall so the control unit freezes its micro-address register while memory is slow.
- Flags bus timeout and misaligned access.

---
 rtl/fetch_mem_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_mem_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_mem_unit.sv
// Multicycle-MIPS front end: owns PC/IR/MDR and the memory request handshake,
// stalling the microcoded control unit while memory is slow and flagging bus faults.
module fetch_mem_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          WAIT_MAX = 8
) (
  input  logic        CLK,
  input  logic        Rst,
  input  logic        PCWr,
  input  logic        PCWrCond,
  input  logic        Zero,
  input  logic [1:0]  PCSrc,
  input  logic        IorD,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic        IRWr,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ALUOut,
  input  logic [31:0] BReg,
  input  logic [31:0] MemRdData,
  input  logic        MemRdy,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemRdEn,
  output logic        MemWrEn,
  output logic        Stall,
  output logic [31:0] PC,
  output logic [31:0] IR,
  output logic [5:0]  Op,
  output logic [31:0] MDR,
  output logic        BusErr,
  output logic        AddrErr
);

  localparam int              CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       acc_addr_p1;
  logic [31:0]       acc_wdata_p1;
  logic              acc_wr_p1;

  logic              req;
  logic [31:0]       idle_addr;
  logic              misal;
  logic              done;
  logic              timeout;
  logic              rd_done;
  logic              pc_we;
  logic [31:0]       pc_next;

  assign req       = MemRd | MemWr;
  assign idle_addr = IorD ? ALUOut : PC;
  assign Op        = IR[31:26];

  // p0: request decode; in WAIT the latched access drives the bus
  always_comb begin
    MemAddr  = idle_addr;
    MemWData = BReg;
    MemRdEn  = 1'b0;
    MemWrEn  = 1'b0;
    Stall    = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    misal    = 1'b0;
    if (state == S_IDLE) begin
      if (req) begin
        if (idle_addr[1:0] != 2'b00) begin
          misal = 1'b1;
        end else begin
          MemWrEn = MemWr;
          MemRdEn = ~MemWr;
          Stall   = ~MemRdy;
          done    = MemRdy;
        end
      end
    end else begin
      MemAddr  = acc_addr_p1;
      MemWData = acc_wdata_p1;
      MemWrEn  = acc_wr_p1;
      MemRdEn  = ~acc_wr_p1;
      if (MemRdy)
        done = 1'b1;
      else if (cnt == CNT_LAST)
        timeout = 1'b1;
      else
        Stall = 1'b1;
    end
    // Strobes must stay quiet while reset is held, independent of the inputs.
    if (!Rst) begin
      MemRdEn = 1'b0;
      MemWrEn = 1'b0;
      Stall   = 1'b0;
      done    = 1'b0;
      timeout = 1'b0;
      misal   = 1'b0;
    end
  end

  assign rd_done = done & MemRdEn;
  assign pc_we   = ~Stall & (PCWr | (PCWrCond & Zero));

  always_comb begin
    case (PCSrc)
      2'b00:   pc_next = ALUResult;
      2'b01:   pc_next = ALUOut;
      2'b10:   pc_next = {PC[31:28], IR[25:0], 2'b00};
      default: pc_next = PC;
    endcase
  end

  // p1: control state, architectural registers and sticky fault flags
  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc_wr_p1 <= 1'b0;
      PC        <= PC_RESET;
      IR        <= '0;
      MDR       <= '0;
      BusErr    <= 1'b0;
      AddrErr   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Stall) begin
            state     <= S_WAIT;
            cnt       <= '0;
            acc_wr_p1 <= MemWr;
          end
        end
        default: begin
          if (done || timeout)
            state <= S_IDLE;
          else
            cnt <= cnt + CNT_W'(1);
        end
      endcase
      if (timeout) BusErr  <= 1'b1;
      if (misal)   AddrErr <= 1'b1;
      if (rd_done) begin
        MDR <= MemRdData;
        if (IRWr) IR <= MemRdData;
      end
      if (pc_we) PC <= pc_next;
    end
  end

  // p1: address and store data captured once so the access survives input changes
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && Stall) begin
      acc_addr_p1  <= MemAddr;
      acc_wdata_p1 <= BReg;
    end
  end

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Directed bench for fetch_mem_unit: fetch, wait states, branch, jump,
// write timeout, misalignment and asynchronous reset during a wait.
module tb_fetch_mem_unit;

  logic        CLK = 1'b0;
  logic        Rst;
  logic        PCWr, PCWrCond, Zero, IorD, MemRd, MemWr, IRWr, MemRdy;
  logic [1:0]  PCSrc;
  logic [31:0] ALUResult, ALUOut, BReg, MemRdData;
  logic [31:0] MemAddr, MemWData, PC, IR, MDR;
  logic        MemRdEn, MemWrEn, Stall, BusErr, AddrErr;
  logic [5:0]  Op;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_mem_unit #(.PC_RESET(32'h0000_0000), .WAIT_MAX(4)) dut (
    .CLK(CLK), .Rst(Rst), .PCWr(PCWr), .PCWrCond(PCWrCond), .Zero(Zero),
    .PCSrc(PCSrc), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr), .IRWr(IRWr),
    .ALUResult(ALUResult), .ALUOut(ALUOut), .BReg(BReg), .MemRdData(MemRdData),
    .MemRdy(MemRdy), .MemAddr(MemAddr), .MemWData(MemWData), .MemRdEn(MemRdEn),
    .MemWrEn(MemWrEn), .Stall(Stall), .PC(PC), .IR(IR), .Op(Op), .MDR(MDR),
    .BusErr(BusErr), .AddrErr(AddrErr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    PCWr = 0; PCWrCond = 0; Zero = 0; PCSrc = 2'b00; IorD = 0;
    MemRd = 0; MemWr = 0; IRWr = 0; MemRdy = 0;
    ALUResult = '0; ALUOut = '0; BReg = '0; MemRdData = '0;
  endtask

  initial begin
    idle_inputs();
    Rst = 0;
    MemRd = 1;
    #2;
    chk("rst_pc", PC, 32'h0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_mdr", MDR, 32'h0);
    chk("rst_stall", {31'b0, Stall}, 32'h0);
    chk("rst_rden", {31'b0, MemRdEn}, 32'h0);
    chk("rst_flags", {30'b0, BusErr, AddrErr}, 32'h0);
    edge_step();
    edge_step();
    Rst = 1;

    // Zero-wait fetch at PC=0
    MemRd = 1; IRWr = 1; PCWr = 1; PCSrc = 2'b00; ALUResult = 32'h4;
    MemRdy = 1; MemRdData = 32'h8C22_0004;
    #1;
    chk("zw_rden", {31'b0, MemRdEn}, 32'h1);
    chk("zw_addr", MemAddr, 32'h0);
    chk("zw_stall", {31'b0, Stall}, 32'h0);
    edge_step();
    chk("zw_ir", IR, 32'h8C22_0004);
    chk("zw_op", {26'b0, Op}, 32'h23);
    chk("zw_mdr", MDR, 32'h8C22_0004);
    chk("zw_pc", PC, 32'h4);

    // Two wait states on the fetch at PC=4
    ALUResult = 32'h8; MemRdy = 0; MemRdData = 32'h1234_5678;
    #1;
    chk("ws1_stall", {31'b0, Stall}, 32'h1);
    chk("ws1_addr", MemAddr, 32'h4);
    edge_step();
    chk("ws1_pc", PC, 32'h4);
    chk("ws1_ir", IR, 32'h8C22_0004);
    IorD = 1; ALUOut = 32'h0000_0200;
    #1;
    chk("ws2_stall", {31'b0, Stall}, 32'h1);
    chk("ws2_addr_latched", MemAddr, 32'h4);
    chk("ws2_rden", {31'b0, MemRdEn}, 32'h1);
    edge_step();
    chk("ws2_pc", PC, 32'h4);
    chk("ws2_ir", IR, 32'h8C22_0004);
    MemRdy = 1; MemRdData = 32'hAABB_CCDD;
    #1;
    chk("ws3_stall", {31'b0, Stall}, 32'h0);
    edge_step();
    chk("ws3_pc", PC, 32'h8);
    chk("ws3_ir", IR, 32'hAABB_CCDD);
    chk("ws3_mdr", MDR, 32'hAABB_CCDD);

    // Conditional branch
    idle_inputs();
    PCWrCond = 1; PCSrc = 2'b01; ALUOut = 32'h40; Zero = 0;
    edge_step();
    chk("br_nt_pc", PC, 32'h8);
    Zero = 1;
    edge_step();
    chk("br_t_pc", PC, 32'h40);

    // Fetch the jump instruction while moving PC to 0x1000_0004
    idle_inputs();
    MemRd = 1; IRWr = 1; PCWr = 1; PCSrc = 2'b01; ALUOut = 32'h1000_0004;
    MemRdy = 1; MemRdData = 32'h0800_0010;
    #1;
    chk("jf_addr", MemAddr, 32'h40);
    edge_step();
    chk("jf_pc", PC, 32'h1000_0004);
    chk("jf_op", {26'b0, Op}, 32'h02);
    idle_inputs();
    PCWr = 1; PCSrc = 2'b10;
    edge_step();
    chk("jmp_pc", PC, 32'h1000_0040);
    PCSrc = 2'b11;
    edge_step();
    chk("hold_pc", PC, 32'h1000_0040);

    // Write that times out; simultaneous read request is suppressed
    idle_inputs();
    MemWr = 1; MemRd = 1; IorD = 1; ALUOut = 32'h100; BReg = 32'hDEAD_BEEF; MemRdy = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_stall", {31'b0, Stall}, 32'h1);
      chk("to_wren", {31'b0, MemWrEn}, 32'h1);
      chk("to_rden", {31'b0, MemRdEn}, 32'h0);
      chk("to_addr", MemAddr, 32'h100);
      chk("to_wdata", MemWData, 32'hDEAD_BEEF);
      edge_step();
      BReg = 32'h0;
      ALUOut = 32'h0000_0300;
    end
    #1;
    chk("to_stall_end", {31'b0, Stall}, 32'h0);
    chk("to_buserr_pre", {31'b0, BusErr}, 32'h0);
    edge_step();
    chk("to_buserr", {31'b0, BusErr}, 32'h1);
    chk("to_mdr", MDR, 32'h0800_0010);
    idle_inputs();
    edge_step();
    edge_step();
    chk("to_buserr_sticky", {31'b0, BusErr}, 32'h1);
    chk("to_idle_stall", {31'b0, Stall}, 32'h0);

    // Misaligned read
    MemRd = 1; IRWr = 1; IorD = 1; ALUOut = 32'h102; MemRdy = 1; MemRdData = 32'hFFFF_FFFF;
    #1;
    chk("mis_rden", {31'b0, MemRdEn}, 32'h0);
    chk("mis_stall", {31'b0, Stall}, 32'h0);
    edge_step();
    chk("mis_addrerr", {31'b0, AddrErr}, 32'h1);
    chk("mis_mdr", MDR, 32'h0800_0010);
    chk("mis_ir", IR, 32'h0800_0010);
    chk("mis_pc", PC, 32'h1000_0040);
    idle_inputs();
    edge_step();
    chk("mis_addrerr_sticky", {31'b0, AddrErr}, 32'h1);

    // Asynchronous reset in the middle of a wait
    MemRd = 1; MemRdy = 0;
    edge_step();
    chk("rw_stall", {31'b0, Stall}, 32'h1);
    #2;
    Rst = 0;
    #1;
    chk("rw_pc", PC, 32'h0);
    chk("rw_stall0", {31'b0, Stall}, 32'h0);
    chk("rw_rden", {31'b0, MemRdEn}, 32'h0);
    chk("rw_flags", {30'b0, BusErr, AddrErr}, 32'h0);
    chk("rw_ir", IR, 32'h0);
    edge_step();
    idle_inputs();
    Rst = 1;
    edge_step();
    chk("rw_idle_stall", {31'b0, Stall}, 32'h0);
    MemRd = 1; MemRdy = 1; MemRdData = 32'h0000_1111;
    #1;
    chk("rw_idle_addr", MemAddr, 32'h0);
    edge_step();
    chk("rw_idle_mdr", MDR, 32'h0000_1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
